// File: rtl/hazard_stall_ctrl_if.sv
// Control-path bundle between the pipeline datapath and hazard_stall_ctrl.
// master drives the ID/EX observations; slave (the controller) drives pipeline enables.
interface hazard_stall_ctrl_if;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic        ex_mem_read;
   logic [4:0]  ex_rd;
   logic        branch_taken;
   logic        mul_start;
   logic        pc_write;
   logic        ifid_write;
   logic        ifid_flush;
   logic        idex_write;
   logic        idex_bubble;
   logic        exmem_bubble;
   logic        mul_done;
   logic [15:0] stall_cycles;
   logic [15:0] flush_count;

   modport master (
      output id_rs1, id_rs2, ex_mem_read, ex_rd, branch_taken, mul_start,
      input  pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
             exmem_bubble, mul_done, stall_cycles, flush_count
   );

   modport slave (
      input  id_rs1, id_rs2, ex_mem_read, ex_rd, branch_taken, mul_start,
      output pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
             exmem_bubble, mul_done, stall_cycles, flush_count
   );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Load-use stall, branch flush and multiply freeze sequencing for the 5-stage core.
// Optional performance counters are built only when HAZARD_PERF_EN is defined.
//
// state      | meaning
// RUN        | normal issue; detects multiply, load-use hazard, taken branch
// LOAD_STALL | one bubble cycle after a load-use stall
// MUL_WAIT   | front frozen while the multiplier finishes; cnt = freeze cycles left
module hazard_stall_ctrl #(
   parameter int MUL_LAT = 4,
   parameter int CNT_W   = 4
) (
   input  logic               clk,
   input  logic               rst,
   hazard_stall_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      LOAD_STALL = 2'd1,
      MUL_WAIT   = 2'd2
   } state_t;

   localparam int              LOAD_INT = (MUL_LAT > 1) ? (MUL_LAT - 2) : 0;
   localparam logic [CNT_W-1:0] CNT_LOAD = LOAD_INT[CNT_W-1:0];

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             hazard;
   logic             pc_write, ifid_write, ifid_flush, idex_write;
   logic             idex_bubble, exmem_bubble, mul_done;

   assign hazard = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                   ((bus.ex_rd == bus.id_rs1) || (bus.ex_rd == bus.id_rs2));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Outputs are forced idle while reset is held, regardless of inputs.
   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      pc_write     = 1'b1;
      ifid_write   = 1'b1;
      ifid_flush   = 1'b0;
      idex_write   = 1'b1;
      idex_bubble  = 1'b0;
      exmem_bubble = 1'b0;
      mul_done     = 1'b0;
      if (!rst) begin
         unique case (state)
            RUN: begin
               if (bus.mul_start) begin
                  if (MUL_LAT == 1) begin
                     mul_done = 1'b1;
                  end else begin
                     pc_write     = 1'b0;
                     ifid_write   = 1'b0;
                     idex_write   = 1'b0;
                     exmem_bubble = 1'b1;
                     cnt_nxt      = CNT_LOAD;
                     state_nxt    = MUL_WAIT;
                  end
               end else if (hazard) begin
                  // branch is held off; it re-resolves once the load data arrives
                  pc_write    = 1'b0;
                  ifid_write  = 1'b0;
                  idex_bubble = 1'b1;
                  state_nxt   = LOAD_STALL;
               end else if (bus.branch_taken) begin
                  ifid_flush = 1'b1;
               end
            end
            LOAD_STALL: begin
               ifid_flush = bus.branch_taken;
               state_nxt  = RUN;
            end
            MUL_WAIT: begin
               if (cnt != '0) begin
                  pc_write     = 1'b0;
                  ifid_write   = 1'b0;
                  idex_write   = 1'b0;
                  exmem_bubble = 1'b1;
                  cnt_nxt      = cnt - {{(CNT_W-1){1'b0}}, 1'b1};
               end else begin
                  mul_done  = 1'b1;
                  state_nxt = RUN;
               end
            end
            default: state_nxt = RUN;
         endcase
      end
   end

   assign bus.pc_write     = pc_write;
   assign bus.ifid_write   = ifid_write;
   assign bus.ifid_flush   = ifid_flush;
   assign bus.idex_write   = idex_write;
   assign bus.idex_bubble  = idex_bubble;
   assign bus.exmem_bubble = exmem_bubble;
   assign bus.mul_done     = mul_done;

`ifdef HAZARD_PERF_EN
   logic [15:0] stall_cnt, flush_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (!pc_write && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
         if (ifid_flush && (flush_cnt != 16'hFFFF))
            flush_cnt <= flush_cnt + 16'd1;
      end
   end

   assign bus.stall_cycles = stall_cnt;
   assign bus.flush_count  = flush_cnt;
`else
   assign bus.stall_cycles = '0;
   assign bus.flush_count  = '0;
`endif

endmodule
